// File: rtl/cpu_memory_pkg.sv
// Shared encodings and helpers for the memory stage: access-width codes, FSM states,
// byte-enable generation and alignment checking.
package cpu_memory_pkg;

    localparam logic [1:0] MEM_BYTE  = 2'd0;
    localparam logic [1:0] MEM_HALF  = 2'd1;
    localparam logic [1:0] MEM_WORD  = 2'd2;
    localparam logic [1:0] MEM_DWORD = 2'd3;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    // Byte enables for an 8-lane bus; narrower buses keep the low bits.
    function automatic logic [7:0] wmask(input logic [1:0] width, input logic [2:0] offset);
        logic [7:0] base;
        case (width)
            MEM_BYTE: base = 8'h01;
            MEM_HALF: base = 8'h03;
            MEM_WORD: base = 8'h0F;
            default:  base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    // A dword access on a 32-bit bus can never be satisfied, so it is reported as misaligned.
    function automatic logic misaligned(input logic [1:0] width, input logic [2:0] addr,
                                        input logic wide);
        case (width)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return addr[0];
            MEM_WORD: return addr[1:0] != 2'b00;
            default:  return !wide || (addr != 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/cpu_memory_align.sv
// Combinational lane handling: extracts and extends the addressed load lane and
// replicates store data across all byte lanes. Zero latency, no flow control.
module cpu_memory_align
    import cpu_memory_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]                  load_width,
    input  logic [$clog2(XLEN/8)-1:0]   load_offset,
    input  logic                        load_signed,
    input  logic [XLEN-1:0]             rdata,
    input  logic [1:0]                  store_width,
    input  logic [XLEN-1:0]             wdata,
    output logic [XLEN-1:0]             load_data,
    output logic [XLEN-1:0]             store_data
);

    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] left;
    int unsigned     shamt;

    // Push the lane to the top, then shift back arithmetically or logically to extend.
    always_comb begin
        lane = rdata >> {load_offset, 3'b000};
        case (load_width)
            MEM_BYTE: shamt = XLEN - 8;
            MEM_HALF: shamt = XLEN - 16;
            MEM_WORD: shamt = XLEN - 32;
            default:  shamt = 0;
        endcase
        left = lane << shamt;
        if (load_signed)
            load_data = $signed(left) >>> shamt;
        else
            load_data = left >> shamt;
    end

    always_comb begin
        case (store_width)
            MEM_BYTE: store_data = {(XLEN/8){wdata[7:0]}};
            MEM_HALF: store_data = {(XLEN/16){wdata[15:0]}};
            MEM_WORD: store_data = {(XLEN/32){wdata[31:0]}};
            default:  store_data = wdata;
        endcase
    end

endmodule

// File: rtl/cpu_memory_stage.sv
// Pipeline memory stage: ALU results and misaligned ops complete in 1 cycle; aligned loads/stores
// hold o_busy and wait on i_bus_ready (bounded by TIMEOUT), requests while busy are dropped.
module cpu_memory_stage
    import cpu_memory_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RD_WIDTH = 5,
    parameter int TIMEOUT  = 255
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_execute,
    input  logic [RD_WIDTH-1:0]   i_inst_rd,
    input  logic [XLEN-1:0]       i_rd,
    input  logic [XLEN-1:0]       i_wdata,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [1:0]            i_mem_width,
    input  logic                  i_mem_signed,
    input  logic                  i_branch,
    input  logic [XLEN-1:0]       i_pc_next,
    output logic                  o_bus_request,
    output logic                  o_bus_rw,
    output logic [XLEN-1:0]       o_bus_address,
    output logic [XLEN-1:0]       o_bus_wdata,
    output logic [XLEN/8-1:0]     o_bus_wmask,
    input  logic                  i_bus_ready,
    input  logic [XLEN-1:0]       i_bus_rdata,
    output logic [RD_WIDTH-1:0]   o_inst_rd,
    output logic [XLEN-1:0]       o_rd,
    output logic                  o_branch,
    output logic [XLEN-1:0]       o_pc_next,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_fault
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [RD_WIDTH-1:0]  cap_inst_rd;
    logic [XLEN-1:0]      cap_rd;
    logic                 cap_branch;
    logic [XLEN-1:0]      cap_pc_next;
    logic [1:0]           cap_width;
    logic                 cap_signed;
    logic                 cap_rw;

    logic                 is_mem;
    logic [2:0]           offset_in;
    logic                 misalign;
    logic                 timed_out;
    logic [XLEN-1:0]      load_data;
    logic [XLEN-1:0]      store_data;

    assign is_mem    = i_mem_read | i_mem_write;
    assign offset_in = 3'(i_rd[OW-1:0]);
    assign misalign  = misaligned(i_mem_width, offset_in, XLEN == 64);
    assign timed_out = (TIMEOUT > 0) && (int'(cnt) == TIMEOUT - 1);

    cpu_memory_align #(.XLEN(XLEN)) u_align (
        .load_width  (cap_width),
        .load_offset (cap_rd[OW-1:0]),
        .load_signed (cap_signed),
        .rdata       (i_bus_rdata),
        .store_width (i_mem_width),
        .wdata       (i_wdata),
        .load_data   (load_data),
        .store_data  (store_data)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            cnt           <= '0;
            cap_inst_rd   <= '0;
            cap_rd        <= '0;
            cap_branch    <= 1'b0;
            cap_pc_next   <= '0;
            cap_width     <= '0;
            cap_signed    <= 1'b0;
            cap_rw        <= 1'b0;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
            o_bus_wmask   <= '0;
            o_inst_rd     <= '0;
            o_rd          <= '0;
            o_branch      <= 1'b0;
            o_pc_next     <= '0;
            o_ready       <= 1'b0;
            o_busy        <= 1'b0;
            o_fault       <= 1'b0;
        end else begin
            o_ready <= 1'b0;
            o_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_execute) begin
                        if (!is_mem || misalign) begin
                            o_inst_rd <= i_inst_rd;
                            o_rd      <= i_rd;
                            o_branch  <= i_branch;
                            o_pc_next <= i_pc_next;
                            o_ready   <= 1'b1;
                            o_fault   <= is_mem;
                        end else begin
                            state         <= ACCESS;
                            cnt           <= '0;
                            cap_inst_rd   <= i_inst_rd;
                            cap_rd        <= i_rd;
                            cap_branch    <= i_branch;
                            cap_pc_next   <= i_pc_next;
                            cap_width     <= i_mem_width;
                            cap_signed    <= i_mem_signed;
                            cap_rw        <= i_mem_write;
                            o_bus_request <= 1'b1;
                            o_busy        <= 1'b1;
                            o_bus_rw      <= i_mem_write;
                            o_bus_address <= {i_rd[XLEN-1:OW], {OW{1'b0}}};
                            o_bus_wdata   <= store_data;
                            o_bus_wmask   <= NB'(wmask(i_mem_width, offset_in));
                        end
                    end
                end
                ACCESS: begin
                    if (i_bus_ready || timed_out) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        o_bus_request <= 1'b0;
                        o_busy        <= 1'b0;
                        o_inst_rd     <= cap_inst_rd;
                        o_branch      <= cap_branch;
                        o_pc_next     <= cap_pc_next;
                        o_ready       <= 1'b1;
                        o_fault       <= !i_bus_ready;
                        o_rd          <= (i_bus_ready && !cap_rw) ? load_data : cap_rd;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_memory_stage.sv
// Directed bench for cpu_memory_stage (XLEN=32, TIMEOUT=4); outputs sampled on the falling edge.
module tb_cpu_memory_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        execute = 1'b0;
    logic [4:0]  inst_rd = '0;
    logic [31:0] rd = '0;
    logic [31:0] wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_width = '0;
    logic        mem_signed = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] pc_next = '0;
    logic        bus_request;
    logic        bus_rw;
    logic [31:0] bus_address;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [4:0]  out_inst_rd;
    logic [31:0] out_rd;
    logic        out_branch;
    logic [31:0] out_pc_next;
    logic        ready;
    logic        busy;
    logic        fault;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_memory_stage #(.XLEN(32), .RD_WIDTH(5), .TIMEOUT(4)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_execute     (execute),
        .i_inst_rd     (inst_rd),
        .i_rd          (rd),
        .i_wdata       (wdata),
        .i_mem_read    (mem_read),
        .i_mem_write   (mem_write),
        .i_mem_width   (mem_width),
        .i_mem_signed  (mem_signed),
        .i_branch      (branch),
        .i_pc_next     (pc_next),
        .o_bus_request (bus_request),
        .o_bus_rw      (bus_rw),
        .o_bus_address (bus_address),
        .o_bus_wdata   (bus_wdata),
        .o_bus_wmask   (bus_wmask),
        .i_bus_ready   (bus_ready),
        .i_bus_rdata   (bus_rdata),
        .o_inst_rd     (out_inst_rd),
        .o_rd          (out_rd),
        .o_branch      (out_branch),
        .o_pc_next     (out_pc_next),
        .o_ready       (ready),
        .o_busy        (busy),
        .o_fault       (fault)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns one falling edge later with i_execute dropped.
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic mr,
                         input logic mw, input logic [1:0] w, input logic s);
        execute = 1'b1; rd = a; wdata = wd;
        mem_read = mr; mem_write = mw; mem_width = w; mem_signed = s;
        @(negedge clk);
        execute = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [31:0] a, input logic [1:0] w,
                            input logic s, input logic [31:0] rdat, input int lat,
                            input logic [31:0] exp);
        int  busy_cnt = 0;
        logic done = 1'b0;
        issue(a, 32'h0, 1'b1, 1'b0, w, s);
        check({tag, "_addr"}, bus_address, {a[31:2], 2'b00});
        bus_rdata = rdat;
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) busy_cnt++;
            bus_ready = busy && (busy_cnt == lat);
            if (ready) begin
                done = 1'b1;
                check({tag, "_rd"}, out_rd, exp);
                check({tag, "_fault"}, fault, 1'b0);
            end else begin
                @(negedge clk);
            end
        end
        bus_ready = 1'b0;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_cycles"}, busy_cnt, lat);
        @(negedge clk);
        check({tag, "_single_pulse"}, ready, 1'b0);
    endtask

    task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] wd,
                             input logic also_read, input logic [1:0] w,
                             input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                             input logic [31:0] exp_wdata);
        issue(a, wd, also_read, 1'b1, w, 1'b0);
        check({tag, "_req"}, bus_request, 1'b1);
        check({tag, "_rw"}, bus_rw, 1'b1);
        check({tag, "_addr"}, bus_address, exp_addr);
        check({tag, "_wmask"}, bus_wmask, exp_mask);
        check({tag, "_wdata"}, bus_wdata, exp_wdata);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        check({tag, "_ready"}, ready, 1'b1);
        check({tag, "_rd"}, out_rd, a);
        check({tag, "_req_drop"}, bus_request, 1'b0);
    endtask

    initial begin
        int  req_cycles;
        logic done;

        #1;
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_req", bus_request, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_rd", out_rd, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ALU pass-through
        inst_rd = 5'd7; branch = 1'b1; pc_next = 32'h44;
        issue(32'h1234, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("alu_ready", ready, 1'b1);
        check("alu_rd", out_rd, 32'h1234);
        check("alu_inst_rd", out_inst_rd, 5'd7);
        check("alu_branch", out_branch, 1'b1);
        check("alu_pc", out_pc_next, 32'h44);
        check("alu_req", bus_request, 1'b0);
        check("alu_fault", fault, 1'b0);
        branch = 1'b0; inst_rd = 5'd3;
        @(negedge clk);
        check("alu_pulse_end", ready, 1'b0);

        run_load("lb_signed",   32'h103, 2'd0, 1'b1, 32'h80FFFFFF, 3, 32'hFFFFFF80);
        run_load("lbu",         32'h103, 2'd0, 1'b0, 32'h80FFFFFF, 2, 32'h00000080);
        run_load("lh_signed",   32'h102, 2'd1, 1'b1, 32'h80FF1234, 1, 32'hFFFF80FF);
        run_load("lhu",         32'h102, 2'd1, 1'b0, 32'h80FF1234, 1, 32'h000080FF);
        run_load("lw",          32'h104, 2'd2, 1'b1, 32'hCAFEF00D, 1, 32'hCAFEF00D);

        run_store("sh",  32'h202, 32'h0000ABCD, 1'b0, 2'd1, 32'h200, 4'b1100, 32'hABCDABCD);
        run_store("sb_rw_both", 32'h001, 32'h0000005A, 1'b1, 2'd0, 32'h000, 4'b0010, 32'h5A5A5A5A);
        run_store("sw",  32'h008, 32'hDEADBEEF, 1'b0, 2'd2, 32'h008, 4'b1111, 32'hDEADBEEF);

        // Misaligned word load and half store
        issue(32'h301, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        check("mis_lw_req", bus_request, 1'b0);
        check("mis_lw_ready", ready, 1'b1);
        check("mis_lw_fault", fault, 1'b1);
        check("mis_lw_rd", out_rd, 32'h301);
        issue(32'h201, 32'h1111, 1'b0, 1'b1, 2'd1, 1'b0);
        check("mis_sh_req", bus_request, 1'b0);
        check("mis_sh_fault", fault, 1'b1);
        @(negedge clk);
        check("mis_fault_clear", fault, 1'b0);

        // Timeout with bus never ready
        issue(32'h400, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        req_cycles = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus_request) req_cycles++;
            if (ready) done = 1'b1;
            else @(negedge clk);
        end
        check("to_done", done, 1'b1);
        check("to_req_cycles", req_cycles, 4);
        check("to_fault", fault, 1'b1);
        check("to_req_drop", bus_request, 1'b0);
        check("to_rd", out_rd, 32'h400);

        // Execute while busy is dropped
        issue(32'h500, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        execute = 1'b1; rd = 32'h9999;
        @(negedge clk);
        execute = 1'b0;
        check("busy_ign_ready", ready, 1'b0);
        check("busy_ign_busy", busy, 1'b1);
        bus_rdata = 32'h11223344; bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        check("busy_ign_done", ready, 1'b1);
        check("busy_ign_rd", out_rd, 32'h11223344);
        @(negedge clk);
        check("busy_ign_no_extra", ready, 1'b0);

        // Asynchronous reset mid-access
        issue(32'h600, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        check("arst_pre_req", bus_request, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", bus_request, 1'b0);
        check("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        inst_rd = 5'd2;
        issue(32'h77, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("arst_next_ready", ready, 1'b1);
        check("arst_next_rd", out_rd, 32'h77);
        check("arst_next_inst_rd", out_inst_rd, 5'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_memory_stage.md
CPU_MEMORY_STAGE -- requirements
Module: cpu_memory_stage

Interface
REQ-001 The block SHALL have one clock, i_clock, and a reset, i_reset, that is asynchronous and active-high.
REQ-002 Parameter XLEN, default 32, SHALL set the data/address width; legal values are 32 and 64.
REQ-003 Parameter RD_WIDTH, default 5, SHALL set the destination-register index width.
REQ-004 Parameter TIMEOUT, default 255, SHALL set the bus wait limit in cycles; 0 disables the timeout.
REQ-005 Ports SHALL be:
- i_clock in 1: clock
- i_reset in 1: async active-high reset
- i_execute in 1: one-cycle request from execute stage
- i_inst_rd in RD_WIDTH: destination register
- i_rd in XLEN: ALU result, or effective address for memory ops
- i_wdata in XLEN: store data (rs2)
- i_mem_read in 1: load op
- i_mem_write in 1: store op
- i_mem_width in 2: 0 byte, 1 half, 2 word, 3 dword (XLEN=64 only)
- i_mem_signed in 1: sign-extend load
- i_branch in 1: branch taken
- i_pc_next in XLEN: next PC
- o_bus_request out 1: bus access active
- o_bus_rw out 1: 1 write, 0 read
- o_bus_address out XLEN: address aligned to XLEN/8 bytes
- o_bus_wdata out XLEN: lane-replicated store data
- o_bus_wmask out XLEN/8: byte enables
- i_bus_ready in 1: access complete
- i_bus_rdata in XLEN: read data
- o_inst_rd out RD_WIDTH, o_rd out XLEN, o_branch out 1, o_pc_next out XLEN: writeback payload
- o_ready out 1: one-cycle completion pulse
- o_busy out 1: stage occupied; upstream holds off
- o_fault out 1: misaligned or timed-out access, valid with o_ready

Function
REQ-006 States SHALL be IDLE and ACCESS.
REQ-007 In IDLE, i_execute with neither mem flag SHALL register the payload (o_rd=i_rd) and pulse o_ready on the next edge: 1-cycle latency.
REQ-008 A misaligned access (half with addr[0]=1; word with addr[1:0]!=0; dword with addr[2:0]!=0) SHALL issue no bus request, and SHALL pulse o_ready with o_fault=1 and o_rd=i_rd after 1 cycle.
REQ-009 An aligned memory op SHALL enter ACCESS, capture the payload, and assert o_bus_request and o_busy from the next cycle until completion.
REQ-010 o_bus_wmask SHALL be 1 byte, 2 bytes, 4 bytes or 8 bytes wide for byte/half/word/dword, shifted by the low address bits; store data SHALL be replicated across lanes.
REQ-011 On i_bus_ready in ACCESS, the block SHALL drop o_bus_request, pulse o_ready, and return to IDLE on the same edge.
REQ-012 Load result SHALL be the addressed lane, sign- or zero-extended to XLEN per i_mem_signed. Store o_rd SHALL equal the captured i_rd.
REQ-013 With TIMEOUT>0, if i_bus_ready has not arrived after TIMEOUT cycles in ACCESS, the block SHALL drop the request, pulse o_ready with o_fault=1, and return to IDLE.
REQ-014 i_execute while o_busy=1 SHALL be ignored.
REQ-015 If i_mem_read and i_mem_write are both set, the op SHALL be treated as a store.
REQ-016 o_ready, o_fault and o_bus_request SHALL be 0 whenever not explicitly asserted above.

Reset
REQ-017 Asserting i_reset SHALL immediately force every output to 0, the state to IDLE and the timeout counter to 0, including mid-access.
REQ-018 The first i_execute after reset deassertion SHALL be accepted.

Structure
REQ-019 Package cpu_memory_pkg SHALL hold the width encoding constants, the state enum and the wmask function.
REQ-020 Lane extraction, extension and replication SHALL live in the combinational sub-module cpu_memory_align.

Verification
REQ-021 ALU pass-through: i_execute with i_rd=0x1234, rd=7 -> o_ready=1 next cycle, o_rd=0x1234, o_inst_rd=7, no bus request.
REQ-022 Signed byte load: addr 0x103, rdata 0x80FFFFFF, ready after 3 cycles -> o_rd=0xFFFFFF80, one o_ready pulse, o_busy high for 3 cycles.
REQ-023 Half store: addr 0x202, wdata 0xABCD -> o_bus_wmask=4'b1100, o_bus_wdata=0xABCDABCD, o_bus_rw=1, o_bus_address=0x200.
REQ-024 Misaligned word load at 0x301 -> no request, o_fault=1, o_ready=1 after 1 cycle.
REQ-025 Timeout: TIMEOUT=4, i_bus_ready held 0 -> request dropped after 4 cycles, o_fault=1 with o_ready.
REQ-026 Reset asserted in ACCESS -> o_bus_request=0 without waiting for a clock edge; next i_execute is accepted normally.
